// File: rtl/modport_fifo.sv
// Single-clock synchronous FIFO with registered read data and sticky-free
// one-cycle overflow/underflow flags.
//
// Ports:
//   wr_clk    - sole clock, all state updates on its rising edge
//   res       - asynchronous active-low reset
//   wr_en     - write request; wdata sampled with it
//   wdata     - write data, WIDTH bits
//   full      - FIFO holds DEPTH entries
//   overflow  - high for one cycle after an edge that rejected a write
//   rd_en     - read request
//   rdata     - registered read data (1-cycle latency, holds otherwise)
//   empty     - FIFO holds 0 entries
//   underflow - high for one cycle after an edge that rejected a read
module modport_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             wr_clk,
   input  logic             res,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             overflow,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rdata_q;
   logic             overflow_q, underflow_q;

   logic             wr_acc, rd_acc;

   // Flags decode from registered count only, so no input-to-output path.
   assign full      = (count_q == FullCount);
   assign empty     = (count_q == '0);
   assign rdata     = rdata_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // A simultaneous read frees a slot, so a full FIFO may still take a write.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge wr_clk or negedge res) begin
      if (!res) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= wr_en && !wr_acc;
         underflow_q <= rd_en && empty;
         if (rd_acc) begin
            rdata_q <= mem[rd_ptr_q];
         end
      end
   end

   // Storage is deliberately not reset; stale entries are unreachable
   // because the pointers and count are.
   always_ff @(posedge wr_clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: tb/tb_modport_fifo.sv
module tb_modport_fifo;

   logic       wr_clk;
   logic       res;
   logic       wr_en;
   logic [7:0] wdata;
   logic       full;
   logic       overflow;
   logic       rd_en;
   logic [7:0] rdata;
   logic       empty;
   logic       underflow;

   typedef struct {
      logic [7:0] rdata;
      logic       full;
      logic       empty;
      logic       ovf;
      logic       unf;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   step_id = 0;

   modport_fifo #(
      .WIDTH(8),
      .DEPTH(16)
   ) dut (
      .wr_clk   (wr_clk),
      .res      (res),
      .wr_en    (wr_en),
      .wdata    (wdata),
      .full     (full),
      .overflow (overflow),
      .rd_en    (rd_en),
      .rdata    (rdata),
      .empty    (empty),
      .underflow(underflow)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   task automatic check(input string name, input int id, input logic [7:0] act,
                        input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h, expected %h", name, id, act, exp);
      end
   endtask

   // Monitor: every cycle the DUT presents a new output state, compare it
   // against the oldest queued expectation.
   always @(negedge wr_clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("rdata", e.id, rdata, e.rdata);
         check("full", e.id, {7'd0, full}, {7'd0, e.full});
         check("empty", e.id, {7'd0, empty}, {7'd0, e.empty});
         check("overflow", e.id, {7'd0, overflow}, {7'd0, e.ovf});
         check("underflow", e.id, {7'd0, underflow}, {7'd0, e.unf});
      end
   end

   // Drive one edge worth of stimulus and queue the expected post-edge state.
   task automatic step(input logic w, input logic [7:0] d, input logic r,
                       input logic [7:0] erd, input logic ef, input logic ee,
                       input logic eo, input logic eu);
      exp_t e;
      wr_en = w;
      wdata = d;
      rd_en = r;
      @(posedge wr_clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      e.rdata = erd;
      e.full  = ef;
      e.empty = ee;
      e.ovf   = eo;
      e.unf   = eu;
      e.id    = step_id;
      exp_q.push_back(e);
      step_id++;
   endtask

   task automatic check_reset_outputs(input int id);
      check("rst_rdata", id, rdata, 8'h00);
      check("rst_full", id, {7'd0, full}, 8'h00);
      check("rst_empty", id, {7'd0, empty}, 8'h01);
      check("rst_overflow", id, {7'd0, overflow}, 8'h00);
      check("rst_underflow", id, {7'd0, underflow}, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      res   = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      wdata = 8'h00;
      #3;
      check_reset_outputs(-1);
      #10;
      res = 1'b1;
      @(posedge wr_clk);
      #1;

      // Underflow from reset: rdata stays 0, empty stays 1.
      step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

      // Three writes then three reads.
      step(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);

      // Fill with 0x00..0x0F, then overflow with 0xAA.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 1'b0, 8'h33, (i == 15), 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, 8'hAA, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 8'(i), 1'b0, (i == 15), 1'b0, 1'b0);
      end

      // Full FIFO with simultaneous write and read.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(8'h80 + i), 1'b0, 8'h0F, (i == 15), 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, 8'h55, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);

      // Empty with simultaneous write and read: write only, underflow, rdata holds.
      step(1'b1, 8'h44, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0);

      // Pointer wrap: write 10, read 10, twice, values 0..19.
      for (int blk = 0; blk < 2; blk++) begin
         for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(blk * 10 + i), 1'b0, (blk == 0) ? 8'h44 : 8'd9,
                 1'b0, 1'b0, 1'b0, 1'b0);
         end
         for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'(blk * 10 + i), 1'b0, (i == 9), 1'b0, 1'b0);
         end
      end

      // Mid-operation asynchronous reset discards buffered data.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'(8'hA0 + i), 1'b0, 8'd19, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge wr_clk);
      #1;
      res = 1'b0;
      #1;
      check_reset_outputs(-2);
      #1;
      res = 1'b1;
      step(1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);

      // Let the monitor drain, bounded.
      for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
         @(negedge wr_clk);
         #1;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/modport_fifo.md
MODPORT_FIFO -- requirements
Module: modport_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of storage entries; SHALL be a power of two, at least 2.
REQ-003 wr_clk  input  1  sole clock; all state updates on its rising edge; read and write sides both use it.
REQ-004 res  input  1  asynchronous active-low reset.
REQ-005 wr_en  input  1  write request.
REQ-006 wdata  input  WIDTH  write data, sampled with wr_en.
REQ-007 full  output  1  FIFO holds DEPTH entries.
REQ-008 overflow  output  1  one-cycle flag: previous edge rejected a write.
REQ-009 rd_en  input  1  read request.
REQ-010 rdata  output  WIDTH  registered read data.
REQ-011 empty  output  1  FIFO holds 0 entries.
REQ-012 underflow  output  1  one-cycle flag: previous edge rejected a read.

Function
REQ-013 Storage SHALL be a DEPTH x WIDTH array with write pointer, read pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and occupancy count (log2(DEPTH)+1 bits, range 0..DEPTH).
REQ-014 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0), both decoded from registered state and valid after each edge.
REQ-015 Write accepted at an edge iff wr_en=1 and (full=0 or a read is accepted at the same edge): wdata stored at wr_ptr, wr_ptr incremented.
REQ-016 Read accepted at an edge iff rd_en=1 and empty=0: mem[rd_ptr] loaded into rdata at that edge (1-cycle latency), rd_ptr incremented.
REQ-017 rdata SHALL hold its previous value on every edge without an accepted read.
REQ-018 count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-019 Full with wr_en=1 and rd_en=1: both accepted, count stays DEPTH, full stays 1, overflow=0.
REQ-020 Empty with wr_en=1 and rd_en=1: write accepted, read rejected, count becomes 1, empty falls, underflow=1 for one cycle, rdata unchanged.
REQ-021 overflow SHALL be 1 for exactly the cycle after any edge where wr_en=1 and the write was rejected, else 0; no state changes on a rejected write.
REQ-022 underflow SHALL be 1 for exactly the cycle after any edge where rd_en=1 and empty=1, else 0; no state changes on a rejected read.
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL preserve strict first-in-first-out ordering.
REQ-024 No combinational path from inputs to outputs; all outputs registered or decoded from registers only.

Reset
REQ-025 res=0 SHALL immediately, independent of wr_clk, force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, underflow=0, rdata=0.
REQ-026 Memory contents SHALL NOT be reset; entries are unreadable until rewritten.
REQ-027 Reset asserted mid-operation SHALL discard all buffered data; the first accepted write after release is the first data read.
REQ-028 First edge after res rises SHALL be a normal operating edge.

Verification
REQ-029 Reset, then write 0x11,0x22,0x33 on 3 edges, then rd_en for 3 edges -> rdata 0x11,0x22,0x33 one per edge, empty=1 after the third read.
REQ-030 Write 16 words 0x00..0x0F -> full=1 after 16th edge; 17th write of 0xAA -> overflow=1 for one cycle, count stays 16; read all 16 -> 0x00..0x0F, no 0xAA.
REQ-031 From reset, rd_en=1 for one edge -> underflow=1 for one cycle, rdata=0x00, empty stays 1.
REQ-032 Full FIFO, wr_en=rd_en=1 with wdata=0x55 -> rdata=oldest entry, full stays 1, overflow=0; 0x55 emerges as the 16th subsequent read.
REQ-033 Write 10, read 10, write 10, read 10 with values 0..19 -> pointers wrap, output order 0..19 exact.
REQ-034 Fill 5 entries, pulse res low between edges -> outputs reset asynchronously; after release write 0x77 and read -> rdata=0x77.
